bram_save_ctrl: RTL and testbench
=================================

BRAM_SAVE_CTRL -- requirements
Module: bram_save_ctrl

Interface
REQ-001 Parameter SECTORS, default 128: number of 512-byte sectors per transfer; power of two, 2..1024.
REQ-002 clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset; it SHALL NOT include bk_loading (no combinational loop through the top-level reset).
REQ-004 downloading  in  1  ROM download in progress.
REQ-005 img_mounted  in  1  one-cycle pulse: a save image was mounted.
REQ-006 img_readonly  in  1  the mounted image is read-only.
REQ-007 img_size  in  64  size in bytes of the mounted image.
REQ-008 osd_status  in  1  OSD menu is open.
REQ-009 autosave  in  1  autosave option is enabled.
REQ-010 load_req  in  1  OSD "Load Backup RAM" level; acts on its rising edge.
REQ-011 save_req  in  1  OSD "Save Backup RAM" level; acts on its rising edge.
REQ-012 bram_change  in  1  one-cycle pulse: the console wrote backup RAM.
REQ-013 sd_ack  in  1  HPS sector acknowledge; high for the whole sector transfer.
REQ-014 sd_lba  out  32  current sector number.
REQ-015 sd_rd / sd_wr  out  1 each  sector read / write request.
REQ-016 bk_ena  out  1  a valid save image is present.
REQ-017 bk_loading  out  1  a load transfer is in progress (the top level holds the console in reset on it).
REQ-018 bk_busy  out  1  a transfer is in progress.
REQ-019 sav_pending  out  1  unsaved backup-RAM changes exist.

Function
REQ-020 bk_ena SHALL clear the cycle after a rising edge of downloading.
REQ-021 bk_ena SHALL set whenever downloading & img_mounted & (img_size != 0) & ~img_readonly; this set has priority over the clear.
REQ-022 sav_pending SHALL set on bram_change & ~osd_status.
REQ-023 Otherwise sav_pending SHALL clear while bk_busy; the set has priority over the clear.
REQ-024 Save trigger SHALL be a rising edge of (save_req | (sav_pending & osd_status & autosave)).
REQ-025 Load triggers SHALL be a rising edge of load_req, or a falling edge of downloading while bk_ena=1.
REQ-026 All triggers SHALL be ignored when bk_ena=0 or in ACTIVE; a trigger ignored while ACTIVE is discarded, not queued.
REQ-027 The FSM SHALL have two states, IDLE and ACTIVE.
REQ-028 In IDLE, on a trigger, the next cycle SHALL give: state ACTIVE, bk_busy=1, sd_lba=0, bk_loading=load, sd_rd=load, sd_wr=~load.
REQ-029 Simultaneous load and save triggers SHALL start a load.
REQ-030 On a rising edge of sd_ack, sd_rd and sd_wr SHALL drop the following cycle.
REQ-031 On a falling edge of sd_ack with sd_lba == SECTORS-1, the FSM SHALL return to IDLE and clear bk_busy and bk_loading.
REQ-032 On any other falling edge of sd_ack, sd_lba SHALL increment by 1 and the request matching the transfer direction SHALL reassert the next cycle.
REQ-033 sd_lba[31:log2(SECTORS)] SHALL remain 0; sd_lba SHALL never wrap.
REQ-034 A rising edge of downloading during ACTIVE SHALL NOT abort the transfer; it runs to completion.
REQ-035 sd_rd and sd_wr SHALL never be high together.
REQ-036 Neither sd_rd nor sd_wr SHALL be high in IDLE.

Reset
REQ-037 On reset, the state SHALL go to IDLE and sd_lba, sd_rd, sd_wr, bk_ena, bk_loading, bk_busy and sav_pending SHALL all be 0.
REQ-038 On reset, every edge-detect register SHALL load its current input value, so that inputs already high produce no trigger.
REQ-039 Reset during ACTIVE SHALL abandon the transfer at once, with no further requests issued.

Structure
REQ-040 Package genesis_bram_pkg SHALL hold the state enum (IDLE, ACTIVE) and the SECTORS default.
REQ-041 One sub-module, edge_det (rise and fall outputs, reset-to-input behaviour per REQ-038), SHALL be instantiated once each for load_req, save trigger, downloading and sd_ack.

Verification
REQ-042 Mount a writable 8 KB image during a download, then drop downloading -> bk_ena=1, a load starts, sd_rd=1 with sd_lba=0, bk_loading=1; after 128 ack pulses bk_loading=0 with final sd_lba=127.
REQ-043 bram_change with osd_status=0, then osd_status=1 with autosave=1 -> sav_pending=1, a save starts (sd_wr=1), sav_pending=0 while busy.
REQ-044 load_req and save_req rise in the same cycle -> sd_rd=1, sd_wr=0.
REQ-045 Read-only image mounted, then load_req pulsed -> bk_ena=0 and no sd_rd ever asserted.
REQ-046 save_req pulsed again at sector 5 of a save -> ignored; exactly 128 writes with sd_lba 0..127 in order.
REQ-047 reset asserted at sector 40 of a load -> the next cycle sd_rd=0, bk_loading=0, bk_busy=0, and no trigger with load_req still high.

Source files
------------

// File: rtl/genesis_bram_pkg.sv
// Shared types and sizing for the backup-RAM save/load controller.
package genesis_bram_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int unsigned SECTORS_DEFAULT = 128;
    localparam int unsigned SECTOR_BYTES    = 512;
    localparam int unsigned LBA_BITS        = 32;

    // Sector-counter width; never narrower than one bit.
    function automatic int unsigned lba_width(input int unsigned sectors);
        return (sectors > 1) ? $clog2(sectors) : 1;
    endfunction

endpackage

// File: rtl/edge_det.sv
// Rise/fall detector. The history register always tracks its input, so
// during reset it loads the live value and an input already high is no edge.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= d;
        end else begin
            q <= d;
        end
    end

    assign rise_c = d & ~q;
    assign fall_c = ~d & q;

endmodule

// File: rtl/bram_save_ctrl.sv
// Backup-RAM save/load sequencer: moves SECTORS sectors between console
// backup RAM and the mounted save image through the HPS sector interface.
module bram_save_ctrl
    import genesis_bram_pkg::*;
#(
    parameter int unsigned SECTORS = SECTORS_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        downloading,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    input  logic        osd_status,
    input  logic        autosave,
    input  logic        load_req,
    input  logic        save_req,
    input  logic        bram_change,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        bk_ena,
    output logic        bk_loading,
    output logic        bk_busy,
    output logic        sav_pending
);

    localparam int unsigned LBA_W = lba_width(SECTORS);
    localparam logic [LBA_W-1:0] LAST_LBA = LBA_W'(SECTORS - 1);

    state_t           state;
    logic [LBA_W-1:0] lba;

    logic save_src_c;
    logic load_rise_c, load_fall_c;
    logic save_rise_c, save_fall_c;
    logic dl_rise_c, dl_fall_c;
    logic ack_rise_c, ack_fall_c;
    logic load_trig_c, save_trig_c;
    logic unused_c;

    assign save_src_c = save_req | (sav_pending & osd_status & autosave);

    edge_det u_load_edge (
        .clk    (clk_sys),
        .reset  (reset),
        .d      (load_req),
        .rise_c (load_rise_c),
        .fall_c (load_fall_c)
    );

    edge_det u_save_edge (
        .clk    (clk_sys),
        .reset  (reset),
        .d      (save_src_c),
        .rise_c (save_rise_c),
        .fall_c (save_fall_c)
    );

    edge_det u_dl_edge (
        .clk    (clk_sys),
        .reset  (reset),
        .d      (downloading),
        .rise_c (dl_rise_c),
        .fall_c (dl_fall_c)
    );

    edge_det u_ack_edge (
        .clk    (clk_sys),
        .reset  (reset),
        .d      (sd_ack),
        .rise_c (ack_rise_c),
        .fall_c (ack_fall_c)
    );

    assign unused_c = load_fall_c ^ save_fall_c;

    // A finished ROM download reloads the save image into backup RAM.
    assign load_trig_c = load_rise_c | (dl_fall_c & bk_ena);
    assign save_trig_c = save_rise_c;

    assign sd_lba = LBA_BITS'(lba);

    // Save image validity: a new download invalidates, a writable mount validates.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bk_ena <= 1'b0;
        end else if (downloading && img_mounted && (img_size != 64'd0) && !img_readonly) begin
            bk_ena <= 1'b1;
        end else if (dl_rise_c) begin
            bk_ena <= 1'b0;
        end
    end

    // Console writes outside the OSD mark the image dirty; any transfer cleans it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sav_pending <= 1'b0;
        end else if (bram_change && !osd_status) begin
            sav_pending <= 1'b1;
        end else if (bk_busy) begin
            sav_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            lba        <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_loading <= 1'b0;
            bk_busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Load wins when both triggers land together.
                    if (bk_ena && (load_trig_c || save_trig_c)) begin
                        state      <= ACTIVE;
                        bk_busy    <= 1'b1;
                        lba        <= '0;
                        bk_loading <= load_trig_c;
                        sd_rd      <= load_trig_c;
                        sd_wr      <= ~load_trig_c;
                    end
                end
                ACTIVE: begin
                    if (ack_rise_c) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                    end else if (ack_fall_c) begin
                        if (lba == LAST_LBA) begin
                            state      <= IDLE;
                            bk_busy    <= 1'b0;
                            bk_loading <= 1'b0;
                        end else begin
                            lba   <= lba + LBA_W'(1);
                            sd_rd <= bk_loading;
                            sd_wr <= ~bk_loading;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_rd_wr_excl: assert property (@(posedge clk_sys) disable iff (reset)
        !(sd_rd && sd_wr));

    a_idle_quiet: assert property (@(posedge clk_sys) disable iff (reset)
        (state == IDLE) |-> !(sd_rd || sd_wr));

endmodule

// File: tb/tb_bram_save_ctrl.sv
// Bench for bram_save_ctrl: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_bram_save_ctrl;

    localparam int unsigned NSEC = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        downloading = 1'b0;
    logic        img_mounted = 1'b0;
    logic        img_readonly = 1'b0;
    logic [63:0] img_size = 64'd0;
    logic        osd_status = 1'b0;
    logic        autosave = 1'b0;
    logic        load_req = 1'b0;
    logic        save_req = 1'b0;
    logic        bram_change = 1'b0;
    logic        sd_ack = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, sav_pending;

    int checks = 0;
    int failures = 0;

    bram_save_ctrl #(.SECTORS(NSEC)) dut (
        .clk_sys     (clk),
        .reset       (reset),
        .downloading (downloading),
        .img_mounted (img_mounted),
        .img_readonly(img_readonly),
        .img_size    (img_size),
        .osd_status  (osd_status),
        .autosave    (autosave),
        .load_req    (load_req),
        .save_req    (save_req),
        .bram_change (bram_change),
        .sd_ack      (sd_ack),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .bk_ena      (bk_ena),
        .bk_loading  (bk_loading),
        .bk_busy     (bk_busy),
        .sav_pending (sav_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a transfer is "active" with a direction, a sector index and
    // whether the current sector's request is still outstanding.
    bit m_ena, m_pend, m_active, m_load, m_req, started;
    int m_sector;
    bit p_load, p_save, p_dl, p_ack;

    always @(posedge clk) begin
        bit src, ld, sv, ar, af, n_ena, n_pend;
        src = save_req | (m_pend & osd_status & autosave);
        if (reset) begin
            m_ena = 0; m_pend = 0; m_active = 0; m_load = 0; m_req = 0; m_sector = 0;
        end else begin
            ld = (load_req && !p_load) || (!downloading && p_dl && m_ena);
            sv = src && !p_save;
            ar = sd_ack && !p_ack;
            af = !sd_ack && p_ack;
            if (downloading && img_mounted && img_size != 0 && !img_readonly) n_ena = 1;
            else if (downloading && !p_dl) n_ena = 0;
            else n_ena = m_ena;
            if (bram_change && !osd_status) n_pend = 1;
            else if (m_active) n_pend = 0;
            else n_pend = m_pend;
            if (!m_active) begin
                if (m_ena && (ld || sv)) begin
                    m_active = 1; m_load = ld; m_sector = 0; m_req = 1;
                end
            end else if (ar) begin
                m_req = 0;
            end else if (af) begin
                if (m_sector == NSEC - 1) begin
                    m_active = 0; m_load = 0;
                end else begin
                    m_sector = m_sector + 1; m_req = 1;
                end
            end
            m_ena = n_ena;
            m_pend = n_pend;
        end
        p_load = load_req; p_save = src; p_dl = downloading; p_ack = sd_ack;
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("sd_lba", 64'(sd_lba), 64'(m_sector));
            chk("sd_rd", 64'(sd_rd), 64'(m_active && m_req && m_load));
            chk("sd_wr", 64'(sd_wr), 64'(m_active && m_req && !m_load));
            chk("bk_ena", 64'(bk_ena), 64'(m_ena));
            chk("bk_loading", 64'(bk_loading), 64'(m_load));
            chk("bk_busy", 64'(bk_busy), 64'(m_active));
            chk("sav_pending", 64'(sav_pending), 64'(m_pend));
            chk("rd_wr_excl", 64'(sd_rd & sd_wr), 64'd0);
        end
    end

    int  rd_rises = 0, wr_rises = 0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    always @(negedge clk) begin
        prev_rd <= sd_rd;
        prev_wr <= sd_wr;
        if (sd_rd === 1'b1 && prev_rd !== 1'b1) rd_rises <= rd_rises + 1;
        if (sd_wr === 1'b1 && prev_wr !== 1'b1) wr_rises <= wr_rises + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (sd_rd === 1'b1 || sd_wr === 1'b1) begin
                ok = 1;
                return;
            end
            step();
        end
    endtask

    // HPS side: acknowledge n sectors starting at index first.
    task automatic serve(input int first, input int n, input bit rd_dir);
        for (int i = 0; i < n; i++) begin
            bit ok;
            wait_req(ok);
            if (!ok) begin
                chk("req_timeout", 64'(sd_rd | sd_wr), 64'd1);
                return;
            end
            chk("serve_lba", 64'(sd_lba), 64'(first + i));
            chk("serve_dir", 64'(sd_rd), 64'(rd_dir));
            sd_ack = 1'b1;
            step();
            step();
            sd_ack = 1'b0;
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_lba", 64'(sd_lba), 64'd0);
        chk("rst_ena", 64'(bk_ena), 64'd0);
        chk("rst_busy", 64'(bk_busy), 64'd0);
        chk("rst_pend", 64'(sav_pending), 64'd0);

        // Writable 8 KB image mounted during download, then download ends.
        downloading = 1'b1;
        step();
        img_size = 64'd8192;
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
        step();
        chk("mount_ena", 64'(bk_ena), 64'd1);
        downloading = 1'b0;
        step();
        chk("load_rd", 64'(sd_rd), 64'd1);
        chk("load_lba0", 64'(sd_lba), 64'd0);
        chk("load_loading", 64'(bk_loading), 64'd1);
        serve(0, NSEC, 1'b1);
        chk("load_done_loading", 64'(bk_loading), 64'd0);
        chk("load_done_busy", 64'(bk_busy), 64'd0);
        chk("load_final_lba", 64'(sd_lba), 64'd127);

        // Autosave on OSD open after a console write.
        bram_change = 1'b1;
        step();
        bram_change = 1'b0;
        step();
        chk("pend_set", 64'(sav_pending), 64'd1);
        osd_status = 1'b1;
        autosave = 1'b1;
        step();
        chk("autosave_wr", 64'(sd_wr), 64'd1);
        chk("autosave_rd", 64'(sd_rd), 64'd0);
        step();
        chk("pend_clr_busy", 64'(sav_pending), 64'd0);
        chk("autosave_busy", 64'(bk_busy), 64'd1);
        serve(0, NSEC, 1'b0);
        osd_status = 1'b0;
        autosave = 1'b0;
        step();

        // Simultaneous load and save: load wins.
        load_req = 1'b1;
        save_req = 1'b1;
        step();
        chk("both_rd", 64'(sd_rd), 64'd1);
        chk("both_wr", 64'(sd_wr), 64'd0);
        load_req = 1'b0;
        save_req = 1'b0;
        serve(0, NSEC, 1'b1);

        // Second save request mid-transfer is discarded.
        w0 = wr_rises;
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        serve(0, 5, 1'b0);
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        step();
        chk("midsave_lba", 64'(sd_lba), 64'd5);
        serve(5, NSEC - 5, 1'b0);
        repeat (4) step();
        chk("write_count", 64'(wr_rises - w0), 64'd128);
        chk("midsave_idle", 64'(bk_busy), 64'd0);

        // Read-only image: no valid save, load requests ignored.
        downloading = 1'b1;
        step();
        chk("ena_clr_dl_rise", 64'(bk_ena), 64'd0);
        img_mounted = 1'b1;
        img_readonly = 1'b1;
        step();
        img_mounted = 1'b0;
        step();
        downloading = 1'b0;
        step();
        r0 = rd_rises;
        load_req = 1'b1;
        step();
        step();
        load_req = 1'b0;
        repeat (5) step();
        chk("ro_ena", 64'(bk_ena), 64'd0);
        chk("ro_no_rd", 64'(rd_rises - r0), 64'd0);
        chk("ro_idle", 64'(bk_busy), 64'd0);

        // Reset in the middle of a load.
        img_readonly = 1'b0;
        downloading = 1'b1;
        step();
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
        step();
        downloading = 1'b0;
        step();
        chk("rl_rd", 64'(sd_rd), 64'd1);
        load_req = 1'b1;
        serve(0, 40, 1'b1);
        chk("rl_lba40", 64'(sd_lba), 64'd40);
        reset = 1'b1;
        downloading = 1'b1;
        step();
        chk("rl_rd_off", 64'(sd_rd), 64'd0);
        chk("rl_loading_off", 64'(bk_loading), 64'd0);
        chk("rl_busy_off", 64'(bk_busy), 64'd0);
        step();
        reset = 1'b0;
        step();
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
        chk("rl_reena", 64'(bk_ena), 64'd1);
        repeat (4) step();
        chk("rl_no_trig_busy", 64'(bk_busy), 64'd0);
        chk("rl_no_trig_rd", 64'(sd_rd), 64'd0);
        load_req = 1'b0;
        step();
        downloading = 1'b0;
        step();
        chk("rl_dl_fall_load", 64'(sd_rd), 64'd1);
        reset = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
